// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream
// clients, holding the grant for a whole packet so messages never interleave.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  ptr, cand, rr_idx, sel_idx, grant_inc;
  logic             rr_found, accept, release_grant, cnt_clr, cnt_inc, last_q;
  logic [CNT_W-1:0] hold_cnt;

  // Scan from the farthest candidate to the nearest so the nearest valid client wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr;
    cand     = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign grant_inc = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = '0;
    tx_send       = 1'b0;
    accept        = 1'b0;
    release_grant = 1'b0;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    sel_idx       = grant_id;
    case (state)
      IDLE: begin
        if (rr_found) begin
          req_ready[rr_idx] = 1'b1;
          accept            = 1'b1;
          sel_idx           = rr_idx;
          state_next        = SEND;
        end
      end
      SEND: begin
        tx_send    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            release_grant = 1'b1;
            state_next    = IDLE;
          end else begin
            cnt_clr    = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // Only the locked client may continue; a silent client loses the lock.
        if (req_valid[grant_id]) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_next          = SEND;
        end else if (hold_cnt == CNT_LAST) begin
          release_grant = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      active   <= 1'b0;
      last_q   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (accept) begin
        tx_data  <= req_data[{sel_idx, 3'b000} +: 8];
        grant_id <= sel_idx;
        last_q   <= req_last[sel_idx];
        active   <= 1'b1;
      end
      if (release_grant) begin
        active <= 1'b0;
        ptr    <= grant_inc;
      end
      if (cnt_clr)      hold_cnt <= '0;
      else if (cnt_inc) hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter that
// records every byte it is asked to send.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int ID_W         = 2;
  localparam int HOLD_TIMEOUT = 16;
  localparam int BOUND        = 200;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_send;
  logic                 tx_busy = 1'b0;
  logic [ID_W-1:0]      grant_id;
  logic                 active;

  int error_count = 0;
  int check_count = 0;

  int         busy_delay = 1;
  int         busy_len   = 4;
  int         dly = 0, bcnt = 0;
  bit         inflight = 1'b0;
  logic [7:0] cur_byte = '0;
  int         sends = 0, bad_send = 0, unstable = 0, ready_leak = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W(ID_W),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises busy_delay cycles after a send and lasts busy_len cycles.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      tx_busy  = 1'b0;
      dly      = 0;
      bcnt     = 0;
      inflight = 1'b0;
    end else begin
      if (tx_busy) begin
        bcnt--;
        if (bcnt == 0) begin
          tx_busy  = 1'b0;
          inflight = 1'b0;
        end
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_busy = 1'b1;
          bcnt    = busy_len;
        end
      end
      if (inflight && tx_data !== cur_byte) unstable++;
      if (tx_send) begin
        if (inflight || tx_busy) bad_send++;
        inflight = 1'b1;
        cur_byte = tx_data;
        dly      = busy_delay;
        sends++;
        sent_q.push_back(tx_data);
      end
    end
  end

  // Any ready bit other than the owner's while a packet is locked is a leak.
  always @(negedge clk) begin
    #3;
    if (!rst && active && ((req_ready & ~(4'(1) << grant_id)) != '0)) ready_leak++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int c, input logic [7:0] d, input logic l);
    int n = 0;
    req_valid[c]     = 1'b1;
    req_data[8*c +: 8] = d;
    req_last[c]      = l;
    #1;
    while (!req_ready[c] && n < BOUND) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput($sformatf("handshake_c%0d_%02h", c, d), 32'(req_ready[c]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[c] = 1'b0;
    req_last[c]  = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((active || tx_busy || inflight) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(n < BOUND), 32'd1);
  endtask

  task automatic waitBusy(input string tag, input logic level);
    int n = 0;
    while (tx_busy !== level && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_busy_wait"}, 32'(tx_busy), 32'(level));
  endtask

  task automatic compareBytes(input string tag);
    checkOutput({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i),
                  (i < sent_q.size()) ? 32'(sent_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    sent_q.delete();
    exp_q.delete();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    repeat (2) @(negedge clk);
    rst        = 1'b0;
    busy_delay = 1;
    sent_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int sends0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_send", 32'(tx_send), 32'd0);
    checkOutput("rst_data", 32'(tx_data), 32'd0);
    checkOutput("rst_grant", 32'(grant_id), 32'd0);
    checkOutput("rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset lands while client 0's first byte is on the wire.
    applyStimulus(0, 8'h41, 1'b0);
    waitBusy("t1", 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("t1_rst_active", 32'(active), 32'd0);
    checkOutput("t1_rst_grant", 32'(grant_id), 32'd0);
    checkOutput("t1_rst_data", 32'(tx_data), 32'd0);
    checkOutput("t1_rst_send", 32'(tx_send), 32'd0);
    checkOutput("t1_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sent_q.delete();
    @(negedge clk);
    applyStimulus(2, 8'hC2, 1'b1);
    checkOutput("t1_grant", 32'(grant_id), 32'd2);
    checkOutput("t1_active", 32'(active), 32'd1);
    waitIdle("t1");
    exp_q = '{8'hC2};
    compareBytes("t1");

    // Two-byte packet from client 1.
    applyStimulus(1, 8'h48, 1'b0);
    applyStimulus(1, 8'h69, 1'b1);
    checkOutput("t2_active_mid", 32'(active), 32'd1);
    checkOutput("t2_grant", 32'(grant_id), 32'd1);
    waitIdle("t2");
    checkOutput("t2_busy_at_release", 32'(tx_busy), 32'd0);
    exp_q = '{8'h48, 8'h69};
    compareBytes("t2");
    checkOutput("t2_send_while_busy", 32'(bad_send), 32'd0);

    // Fairness: all four ask at once, then pointer must have wrapped to 0.
    resetDut();
    fork
      applyStimulus(0, 8'hA0, 1'b1);
      applyStimulus(1, 8'hA1, 1'b1);
      applyStimulus(2, 8'hA2, 1'b1);
      applyStimulus(3, 8'hA3, 1'b1);
    join
    waitIdle("t3a");
    fork
      applyStimulus(3, 8'hB3, 1'b1);
      applyStimulus(0, 8'hB0, 1'b1);
    join
    waitIdle("t3b");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB3};
    compareBytes("t3");

    // Lock: client 2 holds the grant while others wait.
    resetDut();
    applyStimulus(2, 8'h20, 1'b0);
    fork
      begin
        applyStimulus(2, 8'h21, 1'b0);
        applyStimulus(2, 8'h22, 1'b1);
      end
      applyStimulus(0, 8'h0A, 1'b1);
    join
    checkOutput("t4_grant0", 32'(grant_id), 32'd0);
    waitIdle("t4a");
    applyStimulus(2, 8'h23, 1'b0);
    fork
      applyStimulus(2, 8'h24, 1'b1);
      applyStimulus(0, 8'h0C, 1'b1);
      applyStimulus(3, 8'h3B, 1'b1);
    join
    waitIdle("t4b");
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h0A, 8'h23, 8'h24, 8'h3B, 8'h0C};
    compareBytes("t4");
    checkOutput("t4_ready_leak", 32'(ready_leak), 32'd0);

    // Timeout: client 3 goes silent mid-packet while client 0 waits.
    resetDut();
    applyStimulus(3, 8'h33, 1'b0);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h05;
    req_last[0]   = 1'b1;
    waitBusy("t5_rise", 1'b1);
    waitBusy("t5_fall", 1'b0);
    n = 0;
    while (active && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_timeout_cycles", 32'(n), 32'(HOLD_TIMEOUT + 1));
    checkOutput("t5_leak", 32'(ready_leak), 32'd0);
    applyStimulus(0, 8'h05, 1'b1);
    checkOutput("t5_grant", 32'(grant_id), 32'd0);
    waitIdle("t5");
    exp_q = '{8'h33, 8'h05};
    compareBytes("t5");

    // Slow transmitter: busy appears three cycles after the send.
    resetDut();
    busy_delay = 3;
    sends0     = sends;
    applyStimulus(1, 8'h5A, 1'b1);
    waitBusy("t6", 1'b1);
    checkOutput("t6_data_at_busy", 32'(tx_data), 32'h5A);
    checkOutput("t6_sends_at_busy", 32'(sends - sends0), 32'd1);
    waitIdle("t6");
    checkOutput("t6_sends", 32'(sends - sends0), 32'd1);
    checkOutput("t6_unstable", 32'(unstable), 32'd0);
    checkOutput("t6_send_while_busy", 32'(bad_send), 32'd0);
    exp_q = '{8'h5A};
    compareBytes("t6");

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte-stream clients (debug console, Wishbone bridge responses, status reporter, ...). It accepts bytes from clients on a valid/ready handshake and drives the transmitter's send/busy interface one byte at a time. Grant is held for a whole packet, delimited by req_last, so client messages are never interleaved on the wire.

Parameters:
NUM_REQ, 4, number of requesting clients (2..8)
ID_W, 2, width of grant_id; must equal clog2(NUM_REQ)
HOLD_TIMEOUT, 1024, clk cycles a locked client may leave req_valid low mid-packet before its grant is revoked

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-client byte valid
req_data  in  8*NUM_REQ  per-client byte; client i uses bits [8i+7:8i]
req_last  in  NUM_REQ  per-client marker: this byte ends the packet
req_ready  out  NUM_REQ  per-client accept; a transfer occurs when valid and ready are both high
tx_data  out  8  byte to the transmitter, held stable from tx_send until tx_busy falls
tx_send  out  1  single-cycle send pulse to the transmitter
tx_busy  in  1  transmitter busy; rises the cycle after an accepted send and falls after the stop bit
grant_id  out  ID_W  index of the client currently owning the transmitter
active  out  1  high while a packet is in progress (lock held)

Behaviour:
- Reset values: req_ready=0, tx_send=0, tx_data=0, grant_id=0, active=0. Round-robin pointer=0, timeout counter=0, state=IDLE.
- A reset asserted mid-operation aborts immediately. The partial packet is dropped and no state is retained.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE:
  - Search req_valid starting at the pointer, wrapping modulo NUM_REQ. The first valid client i wins.
  - req_ready[i] is high combinationally in that same cycle; all other ready bits stay 0.
  - On the transfer: latch req_data[i] into tx_data, set grant_id=i, set active=1, latch req_last[i] internally, go to SEND.
  - If no client is valid, remain in IDLE.
- SEND: tx_send=1 for exactly one cycle, then go to WAIT_BUSY. A byte accepted at cycle T gives tx_send at T+1 and tx_busy at T+2.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. tx_send is never re-asserted here.
- WAIT_DONE: wait for tx_busy=0.
  - If the latched last=1: active=0, pointer=grant_id+1 (modulo NUM_REQ), go to IDLE.
  - Otherwise: clear the timeout counter and go to HOLD.
- HOLD:
  - Only the locked client is considered. req_ready[grant_id]=1 while req_valid[grant_id]=1.
  - On the transfer: latch data and last, go to SEND.
  - Valid bits from other clients are ignored.
  - While req_valid[grant_id]=0 the counter increments. When it reaches HOLD_TIMEOUT-1: active=0, pointer=grant_id+1, go to IDLE. A revoked client must re-arbitrate.
- tx_send is never asserted while tx_busy=1. At most one byte is in flight.
- Single-byte packets (last=1 on the first byte) release the grant after that byte.
- If one client is the only requester, it regains the grant from IDLE after its packet ends, with no extra dead cycles beyond the IDLE cycle.
- The pointer advances only on packet end or timeout, never per byte.
- Fairness: with every client continuously valid, packets are served 0,1,2,3,0,...

Test Plan:
- Reset mid-packet: client 0 sends 0x41 (last=0), rst pulses during WAIT_DONE -> all outputs return to reset values; the next request from client 2 is granted with grant_id=2.
- Single client 1 sends a packet 0x48,0x69 (last on 0x69) -> tx_send pulses twice, tx_data=0x48 then 0x69. Each pulse occurs only after tx_busy has fallen. active falls after the second byte's busy ends.
- All four clients valid with 1-byte packets 0xA0..0xA3 -> transmit order is 0xA0,0xA1,0xA2,0xA3, and the pointer wraps back to 0.
- Client 2 is locked mid-packet while client 0 asserts valid -> req_ready[0] stays 0 until client 2 presents last. The next grant after that is client 3 if valid, else client 0.
- Client 3 stalls mid-packet with HOLD_TIMEOUT=16 -> active drops after 16 idle cycles, and a waiting client 0 is then granted.
- Transmitter model with tx_busy delayed 3 cycles after tx_send -> controller stays in WAIT_BUSY, issues no second pulse, and tx_data is held stable throughout.
